// File: rtl/layer2_pool_writer.sv
`default_nettype none
// ============================================================================
// Module   : layer2_pool_writer
// Brief    : Captures layer-2 conv beats (bias add, ReLU, saturate) into an
//            OH x OW plane, then 2x2 max-pools it into the feature memory.
// Revision : 1.0
// ============================================================================
module layer2_pool_writer #(
    parameter int OH       = 12,
    parameter int OW       = 12,
    parameter int ADDR_LEN = 7,
    parameter int OC       = 15,
    parameter int OUT_AW   = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     store,
    input  logic [ADDR_LEN:0]        address,
    input  logic signed [7:0]        result,
    input  logic signed [7:0]        bias,
    input  logic [3:0]               out_c,
    input  logic                     pool,
    output logic                     pool_done,
    output logic                     wr_en,
    output logic [OUT_AW-1:0]        wr_addr,
    output logic signed [7:0]        wr_data,
    output logic                     busy,
    output logic                     err
);

    localparam int c_NPIX  = OH * OW;
    localparam int c_PH    = OH / 2;
    localparam int c_PW    = OW / 2;
    localparam int c_NWIN  = c_PH * c_PW;
    localparam int c_IDX_W = (c_NPIX > 1) ? $clog2(c_NPIX) : 1;
    localparam int c_PR_W  = (c_PH > 1) ? $clog2(c_PH) : 1;
    localparam int c_PC_W  = (c_PW > 1) ? $clog2(c_PW) : 1;

    // DRAIN covers the two-stage window pipeline so pool_done trails the last write
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_POOL  = 3'd1;
    localparam logic [2:0] c_DRAIN = 3'd2;
    localparam logic [2:0] c_DONE  = 3'd3;
    localparam logic [2:0] c_WAIT  = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_next;
    logic signed [7:0]       r_buf [0:c_NPIX-1];
    logic [3:0]              r_cq;
    logic [c_PR_W-1:0]       r_pr;
    logic [c_PC_W-1:0]       r_pc;
    logic                    r_s1_valid;
    logic signed [7:0]       r_s1_q0, r_s1_q1, r_s1_q2, r_s1_q3;
    logic [OUT_AW-1:0]       r_s1_addr;
    logic                    r_wr_en;
    logic [OUT_AW-1:0]       r_wr_addr;
    logic signed [7:0]       r_wr_data;
    logic                    r_pool_done;
    logic                    r_err;

    logic [8:0]              w_sum;
    logic signed [7:0]       w_sat;
    logic                    w_idle;
    logic                    w_addr_ok;
    logic                    w_buf_we;
    logic                    w_store_err;
    logic                    w_pool_go;
    logic                    w_oc_err;
    logic                    w_last_win;
    logic                    w_busy;
    logic                    w_win_active;
    logic                    w_done_set;
    int                      w_base;
    logic [c_IDX_W-1:0]      w_i00, w_i01, w_i10, w_i11;
    logic [OUT_AW-1:0]       w_waddr;
    logic signed [7:0]       w_max;

    function automatic logic signed [7:0] smax(input logic signed [7:0] a,
                                               input logic signed [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Bias add in 9 bits, then ReLU and clamp to the positive 8-bit range
    assign w_sum = {result[7], result} + {bias[7], bias};

    always_comb begin
        w_sat = w_sum[7:0];
        if (w_sum[8]) begin
            w_sat = 8'sd0;
        end else if (w_sum[7]) begin
            w_sat = 8'sd127;
        end
    end

    assign w_idle      = (r_state == c_IDLE);
    assign w_addr_ok   = (int'(address) < c_NPIX);
    assign w_buf_we    = w_idle && store && w_addr_ok;
    assign w_store_err = store && (!w_idle || !w_addr_ok);
    assign w_pool_go   = w_idle && pool && !store;
    assign w_oc_err    = w_pool_go && (int'(out_c) >= OC);
    assign w_last_win  = (int'(r_pr) == c_PH - 1) && (int'(r_pc) == c_PW - 1);

    assign w_base  = 2 * int'(r_pr) * OW + 2 * int'(r_pc);
    assign w_i00   = c_IDX_W'(w_base);
    assign w_i01   = c_IDX_W'(w_base + 1);
    assign w_i10   = c_IDX_W'(w_base + OW);
    assign w_i11   = c_IDX_W'(w_base + OW + 1);
    assign w_waddr = OUT_AW'(int'(r_cq) * c_NWIN + int'(r_pr) * c_PW + int'(r_pc));
    assign w_max   = smax(smax(r_s1_q0, r_s1_q1), smax(r_s1_q2, r_s1_q3));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:  if (w_pool_go) w_next = c_POOL;
            c_POOL:  if (w_last_win) w_next = c_DRAIN;
            c_DRAIN: w_next = c_DONE;
            c_DONE:  w_next = c_WAIT;
            c_WAIT:  if (!pool) w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
    end

    // State-decoded controls
    always_comb begin
        w_busy       = 1'b1;
        w_win_active = 1'b0;
        w_done_set   = 1'b0;
        case (r_state)
            c_IDLE:  w_busy       = 1'b0;
            c_POOL:  w_win_active = 1'b1;
            c_DONE:  w_done_set   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < c_NPIX; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_buf_we) begin
            r_buf[c_IDX_W'(address)] <= w_sat;
        end
    end

    // Window walker: pc runs fastest, wrapping into pr
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cq <= '0;
            r_pr <= '0;
            r_pc <= '0;
        end else if (w_pool_go) begin
            r_cq <= out_c;
            r_pr <= '0;
            r_pc <= '0;
        end else if (w_win_active) begin
            if (int'(r_pc) == c_PW - 1) begin
                r_pc <= '0;
                if (int'(r_pr) == c_PH - 1) begin
                    r_pr <= '0;
                end else begin
                    r_pr <= r_pr + 1'b1;
                end
            end else begin
                r_pc <= r_pc + 1'b1;
            end
        end
    end

    // Stage 1 reads the window, stage 2 reduces it and drives the memory port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_q0     <= '0;
            r_s1_q1     <= '0;
            r_s1_q2     <= '0;
            r_s1_q3     <= '0;
            r_s1_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_pool_done <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_s1_valid <= w_win_active;
            if (w_win_active) begin
                r_s1_q0   <= r_buf[w_i00];
                r_s1_q1   <= r_buf[w_i01];
                r_s1_q2   <= r_buf[w_i10];
                r_s1_q3   <= r_buf[w_i11];
                r_s1_addr <= w_waddr;
            end
            r_wr_en <= r_s1_valid;
            if (r_s1_valid) begin
                r_wr_addr <= r_s1_addr;
                r_wr_data <= w_max;
            end
            r_pool_done <= w_done_set;
            if (w_store_err || w_oc_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign pool_done = r_pool_done;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = w_busy;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/layer2_pool_writer.md
Name: layer2_pool_writer

Overview:
Receiving end of the layer-2 convolution output stream, and responder to its pool/pool_done handshake. It captures each store/address/result/bias beat into an OH x OW plane buffer after bias add, ReLU and saturation. On pool request it 2x2 max-pools the plane, writes one pooled channel to the layer-2 feature memory at an out_c-based offset, then pulses pool_done.

Parameters:
OH, 12, conv output plane height
OW, 12, conv output plane width
ADDR_LEN, 7, store address is [ADDR_LEN:0]
OC, 15, output channels
OUT_AW, 10, pooled memory address width

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
store  in  1  one conv result beat valid this cycle
address  in  ADDR_LEN+1  plane index, row*OW+col
result  in  8  signed adder-tree sum
bias  in  8  signed bias for current out_c
out_c  in  4  current output channel
pool  in  1  pool request level from layer control
pool_done  out  1  single-cycle completion pulse
wr_en  out  1  pooled memory write strobe
wr_addr  out  OUT_AW  pooled memory address
wr_data  out  8  signed pooled value
busy  out  1  high while not in IDLE
err  out  1  sticky protocol error flag

Behaviour:
- Reset (rst high at clk edge): FSM to IDLE; pool_done, wr_en, busy, err = 0; wr_addr, wr_data = 0; all buffer entries = 0. Reset wins over every other input, including mid-pool. An aborted pool emits no pool_done and no further writes.
- Write path (IDLE only):
  - On store=1, compute s = sext9(result) + sext9(bias).
  - v = 0 if s<0; 127 if s>127; else s[7:0].
  - buf[address] <= v at that edge; usable by a pool starting the next cycle.
  - address >= OH*OW: write dropped, err <= 1.
- Store in any non-IDLE state: beat dropped, err <= 1.
- FSM states:
  - IDLE: pool=1 and store=0 -> POOL. At that edge: latch out_c as c_q; pr=pc=0. If pool=1 and store=1 in the same cycle, the store is written and POOL is entered the following cycle.
  - POOL: one window per cycle.
    - wr_en=1.
    - wr_data = signed max of buf[2pr][2pc], buf[2pr][2pc+1], buf[2pr+1][2pc], buf[2pr+1][2pc+1].
    - wr_addr = c_q*PH*PW + pr*PW + pc, with PH=OH/2, PW=OW/2 (floor; an odd last row/col is discarded).
    - pc wraps at PW-1 and increments pr. After window (PH-1,PW-1) -> DONE.
    - wr_en, wr_addr and wr_data are registered, so write k appears on the cycle after the window is selected.
  - DONE: pool_done=1 for exactly one cycle; wr_en=0 -> WAIT.
  - WAIT: stay while pool=1 (no re-trigger on a held level); pool=0 -> IDLE.
- Latency: pool sampled at edge E0. PH*PW consecutive wr_en cycles (36 at defaults) start at E0+2, and pool_done follows in the next cycle (E0+38).
- wr_en is never high outside the POOL-driven window; wr_addr/wr_data hold their last values when wr_en=0.
- c_q >= OC at pool start: err <= 1 and pooling proceeds (wr_addr still computed; OUT_AW must cover OC*PH*PW).
- The buffer is not cleared between channels; every entry is overwritten by the next channel's stores.

Test Plan:
- Saturation: store addr 0 with result=100, bias=50 -> buf 127; addr 1 with result=-20, bias=5 -> 0; addr 2 with result=30, bias=-10 -> 20.
- Full channel: fill buf[i]=i%100 via 144 stores, out_c=3, raise pool -> 36 writes; first write wr_addr=108, wr_data=13; pool_done pulses once, 38 cycles after the pool sample edge.
- Held request: keep pool=1 for 100 cycles after pool_done -> no second pool; drop pool, raise again -> a new 36-write burst.
- Protocol error: store during POOL, and store with address=150 -> buffer unchanged, err=1 and held until rst.
- Reset abort: assert rst at the 10th write of a burst -> wr_en=0 and busy=0 next cycle, no pool_done, buffer reads 0.
- Odd plane (OH=OW=5): fill, then pool -> exactly 4 writes; row 4 and column 4 are ignored.
